// File: rtl/mems_pkg.sv
// Shared types and constants for the MEMS frame path: reader FSM states, bus widths
// and the counter pattern laid down by the upstream pattern/sample writer.
package mems_pkg;

    localparam int AVM_ADDR_W = 32;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Byte the writer stores at frame index idx: the low byte of the index.
    function automatic logic [BYTE_W-1:0] expected_byte(input logic [31:0] idx);
        return idx[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/onchip_frame_reader_if.sv
// Avalon-MM read-master and Avalon-ST source signal bundle for onchip_frame_reader.
// master = the reader side, slave = memory plus stream sink side.
interface onchip_frame_reader_if;
    import mems_pkg::*;

    logic [AVM_ADDR_W-1:0] avm_address;
    logic                  avm_read;
    logic [BYTE_W-1:0]     avm_readdata;
    logic                  avm_readdatavalid;
    logic                  avm_waitrequest;
    logic [BYTE_W-1:0]     st_data;
    logic                  st_valid;
    logic                  st_ready;
    logic                  st_sop;
    logic                  st_eop;

    modport master (
        output avm_address, avm_read,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_readdata, avm_readdatavalid, avm_waitrequest,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );

endinterface

// File: rtl/onchip_rd_fifo.sv
// Synchronous first-word-fall-through byte FIFO; push and pop may coincide at any fill
// level, so a full FIFO can accept a push in the same cycle it is popped.
module onchip_rd_fifo
    import mems_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [BYTE_W-1:0]                  din,
    output logic [BYTE_W-1:0]                  dout,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push_s, do_pop_s;

    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Control registers; reset flushes the FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written on accepted push.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == CW'(0));
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign count = count_q;

endmodule

// File: rtl/onchip_frame_reader.sv
// Reads one DEPTH-byte frame from on-chip memory and re-emits it as an SOP/EOP-framed byte stream.
// Optional stream pattern checker enabled by defining ONCHIP_READER_CHECKER_EN.
module onchip_frame_reader
    import mems_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          DEPTH      = 4096,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             err_count_o,
    output logic                    err_flag_o,
    onchip_frame_reader_if.master   bus
);
    localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] LAST_IDX = 32'(DEPTH - 1);
    localparam logic [31:0] END_IDX  = 32'(DEPTH);

    rd_state_e         state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [31:0]       rd_idx_q, rd_idx_d, out_idx_q, out_idx_d;
    logic [CNT_W-1:0]  outst_q, outst_d;

    logic [BYTE_W-1:0] fifo_dout_s;
    logic              fifo_empty_s, fifo_full_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W:0]    credit_sum_s;
    logic              credit_ok_s, avm_read_s, accept_s, push_s, xfer_s;

    // Reads in flight plus bytes already buffered can never exceed the FIFO, so no overflow.
    assign credit_sum_s = {1'b0, fifo_count_s} + {1'b0, outst_q};
    assign credit_ok_s  = !fifo_full_s && (credit_sum_s < (CNT_W+1)'(FIFO_DEPTH));
    assign avm_read_s   = (state_q == ST_ISSUE) && credit_ok_s;
    assign accept_s     = avm_read_s && !bus.avm_waitrequest;
    assign push_s       = bus.avm_readdatavalid && (outst_q != CNT_W'(0));
    assign xfer_s       = !fifo_empty_s && bus.st_ready;

    onchip_rd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (xfer_s),
        .din   (bus.avm_readdata),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    // FSM next-state, index counters and outstanding-read tracking.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_idx_d  = rd_idx_q;
        out_idx_d = xfer_s ? out_idx_q + 32'd1 : out_idx_q;
        if (accept_s && !push_s) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!accept_s && push_s) begin
            outst_d = outst_q - CNT_W'(1);
        end else begin
            outst_d = outst_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    busy_d    = 1'b1;
                    rd_idx_d  = 32'd0;
                    out_idx_d = 32'd0;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    rd_idx_d = rd_idx_q + 32'd1;
                    state_d  = (rd_idx_q == LAST_IDX) ? ST_DRAIN : ST_ISSUE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if ((outst_q == CNT_W'(0)) && fifo_empty_s && (out_idx_q == END_IDX)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_idx_q  <= 32'd0;
            out_idx_q <= 32'd0;
            outst_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_idx_q  <= rd_idx_d;
            out_idx_q <= out_idx_d;
            outst_q   <= outst_d;
        end
    end

    // Address and read are pure functions of held state, so they stay put under waitrequest.
    assign bus.avm_read    = avm_read_s;
    assign bus.avm_address = BASE_ADDR + rd_idx_q;
    assign bus.st_valid    = !fifo_empty_s;
    assign bus.st_data     = fifo_dout_s;
    assign bus.st_sop      = !fifo_empty_s && (out_idx_q == 32'd0);
    assign bus.st_eop      = !fifo_empty_s && (out_idx_q == LAST_IDX);
    assign busy_o          = busy_q;
    assign done_o          = done_q;

`ifdef ONCHIP_READER_CHECKER_EN
    logic [15:0] err_count_q, err_count_d;
    logic        err_flag_q, err_flag_d;

    // Saturating count of streamed bytes that break the writer's counter pattern.
    always_comb begin
        err_count_d = err_count_q;
        if (xfer_s && (fifo_dout_s != expected_byte(out_idx_q)) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
        err_flag_d = err_flag_q || (err_count_d != 16'd0);
    end

    // Error registers; cleared only by reset, never by start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count_q <= 16'd0;
            err_flag_q  <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign err_count_o = err_count_q;
    assign err_flag_o  = err_flag_q;
`else
    assign err_count_o = 16'd0;
    assign err_flag_o  = 1'b0;
`endif

endmodule
